// File: rtl/dummy_reg.sv
// dummy_reg: registered pass-through with LATENCY pipeline stages.
// Optional input X/Z checker enabled by defining DUMMY_REG_XCHECK_EN.
module dummy_reg #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] data_in_i,
    output logic [DATA_W-1:0] data_out_o
);

    logic [DATA_W-1:0] r_stg [LATENCY];

    // Shift the word one stage per edge; reset clears every stage
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stg[k] <= '0;
            end
        end else begin
            r_stg[0] <= data_in_i;
            for (int k = 1; k < LATENCY; k++) begin
                r_stg[k] <= r_stg[k-1];
            end
        end
    end

    assign data_out_o = r_stg[LATENCY-1];

`ifdef DUMMY_REG_XCHECK_EN
    logic [31:0] xcheck_cnt;

    // Flag and count every edge that samples an X/Z input bit
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            xcheck_cnt <= '0;
        end else if ((^data_in_i) === 1'bx) begin
            $warning("dummy_reg: unknown input at %0t: %h", $time, data_in_i);
            xcheck_cnt <= xcheck_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dummy_reg.sv
// tb_dummy_reg: scoreboard bench for dummy_reg at LATENCY 1..4.
// Expected words are queued per latency when driven, popped per edge.
module tb_dummy_reg;

    localparam int NL = 4;
    localparam int LAT [NL] = '{1, 2, 3, 4};

    logic        clk = 1'b0;
    logic        r_rst = 1'b1;
    logic [31:0] r_din = '0;
    logic [31:0] w_out [NL];

    logic [31:0] sb [NL][$];
    logic [31:0] exp_q [NL];

    int checks = 0;
    int errors = 0;
    int n_unk  = 0;

    always #5 clk = ~clk;

    dummy_reg u_l1 (
        .clk_i      (clk),
        .reset_i    (r_rst),
        .data_in_i  (r_din),
        .data_out_o (w_out[0])
    );

    dummy_reg #(.DATA_W(32), .LATENCY(2)) u_l2 (
        .clk_i      (clk),
        .reset_i    (r_rst),
        .data_in_i  (r_din),
        .data_out_o (w_out[1])
    );

    dummy_reg #(.DATA_W(32), .LATENCY(3)) u_l3 (
        .clk_i      (clk),
        .reset_i    (r_rst),
        .data_in_i  (r_din),
        .data_out_o (w_out[2])
    );

    dummy_reg #(.DATA_W(32), .LATENCY(4)) u_l4 (
        .clk_i      (clk),
        .reset_i    (r_rst),
        .data_in_i  (r_din),
        .data_out_o (w_out[3])
    );

    // Drive one edge, update scoreboards, leave exp_q holding the
    // expected output of each instance just after that edge.
    task automatic step(input logic rst, input logic [31:0] d);
        @(negedge clk);
        r_rst = rst;
        r_din = d;
        if (!rst && $isunknown(d)) n_unk++;
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (rst) begin
                sb[k].delete();
                for (int j = 1; j < LAT[k]; j++) sb[k].push_back('0);
                exp_q[k] = '0;
            end else begin
                sb[k].push_back(d);
                exp_q[k] = sb[k].pop_front();
            end
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            step(1'b1, 32'h0);
            for (int k = 0; k < NL; k++) begin
                checks++;
                if (w_out[k] !== 32'h0) begin
                    errors++;
                    $display("FAIL reset L%0d edge%0d: got %h want %h",
                             LAT[k], c, w_out[k], 32'h0);
                end
            end
        end
    endtask

    task automatic test_pass();
        step(1'b0, 32'h12345678);
        checks++;
        if (w_out[0] !== 32'h12345678) begin
            errors++;
            $display("FAIL pass L1 first: got %h want %h",
                     w_out[0], 32'h12345678);
        end
        for (int c = 0; c < 4; c++) begin
            step(1'b0, (c == 3) ? 32'hA5A5_0F0F : 32'h12345678);
            for (int k = 0; k < NL; k++) begin
                checks++;
                if (w_out[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL pass L%0d c%0d: got %h want %h",
                             LAT[k], c, w_out[k], exp_q[k]);
                end
            end
        end
        checks++;
        if (w_out[0] !== 32'hA5A5_0F0F) begin
            errors++;
            $display("FAIL pass L1 new: got %h want %h",
                     w_out[0], 32'hA5A5_0F0F);
        end
    endtask

    task automatic test_unknown();
        logic [31:0] pat [10];
        pat = '{32'h1111_1111, {32{1'bx}}, 32'h2222_2222,
                32'h3333_3333, {32{1'bz}}, {32{1'bz}},
                {32{1'bz}}, 32'h4444_4444, 32'h5555_5555,
                32'h6666_6666};
        for (int c = 0; c < 10; c++) begin
            step(1'b0, pat[c]);
            for (int k = 0; k < NL; k++) begin
                checks++;
                if (w_out[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL unknown L%0d c%0d: got %h want %h",
                             LAT[k], c, w_out[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_midstream();
        step(1'b0, 32'd1);
        step(1'b0, 32'd2);
        step(1'b0, 32'd3);
        step(1'b1, 32'd0);
        checks++;
        if (w_out[2] !== 32'h0) begin
            errors++;
            $display("FAIL mid L3 reset: got %h want %h",
                     w_out[2], 32'h0);
        end
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 32'd10 + 32'(c));
            checks++;
            if (w_out[2] !== exp_q[2] ||
                w_out[2] inside {32'd1, 32'd2, 32'd3}) begin
                errors++;
                $display("FAIL mid L3 c%0d: got %h want %h",
                         c, w_out[2], exp_q[2]);
            end
        end
    endtask

    task automatic test_sweep();
        step(1'b1, 32'h0);
        for (int c = 0; c < 100; c++) begin
            step(1'b0, 32'h100 + 32'(c));
            for (int k = 0; k < NL; k++) begin
                checks++;
                if (w_out[k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL sweep L%0d c%0d: got %h want %h",
                             LAT[k], c, w_out[k], exp_q[k]);
                end
            end
        end
        checks++;
        if (w_out[3] !== 32'h100 + 32'd96) begin
            errors++;
            $display("FAIL sweep L4 final: got %h want %h",
                     w_out[3], 32'h100 + 32'd96);
        end
    endtask

`ifdef DUMMY_REG_XCHECK_EN
    task automatic test_xcheck();
        checks++;
        if (u_l1.xcheck_cnt !== 32'(n_unk)) begin
            errors++;
            $display("FAIL xcheck cnt: got %0d want %0d",
                     u_l1.xcheck_cnt, n_unk);
        end
        step(1'b1, 32'h0);
        checks++;
        if (u_l1.xcheck_cnt !== 32'd0) begin
            errors++;
            $display("FAIL xcheck clr: got %0d want 0",
                     u_l1.xcheck_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pass();
        test_unknown();
`ifdef DUMMY_REG_XCHECK_EN
        test_xcheck();
`endif
        test_midstream();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
